// File: rtl/rom_checker.sv
// Purpose: locks onto a cyclic 32-byte reference stream, then counts compared bytes and mismatches.
// Latency: 1 cycle from a sampled strobe to O_LOCKED/O_ERROR/counters; backpressure: none, one byte per cycle.
module rom_checker #(
    parameter int unsigned LOCK_CNT   = 32,
    parameter int unsigned UNLOCK_CNT = 4,
    parameter int unsigned ERR_W      = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             I_STB,
    input  logic [7:0]       I_DAT,
    output logic             O_LOCKED,
    output logic             O_ERROR,
    output logic [ERR_W-1:0] O_ERR_CNT,
    output logic [31:0]      O_BYTE_CNT
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] SYNC_BYTE  = 8'd157;
    localparam logic [8:0] LOCK_LIM   = 9'(LOCK_CNT);
    localparam logic [8:0] UNLOCK_LIM = 9'(UNLOCK_CNT);

    function automatic logic [7:0] exp_byte(input logic [4:0] idx);
        logic [7:0] b;
        case (idx)
            5'd0:  b = 8'd157;  5'd1:  b = 8'd254;  5'd2:  b = 8'd208;  5'd3:  b = 8'd125;
            5'd4:  b = 8'd39;   5'd5:  b = 8'd192;  5'd6:  b = 8'd242;  5'd7:  b = 8'd117;
            5'd8:  b = 8'd186;  5'd9:  b = 8'd94;   5'd10: b = 8'd201;  5'd11: b = 8'd156;
            5'd12: b = 8'd224;  5'd13: b = 8'd120;  5'd14: b = 8'd255;  5'd15: b = 8'd219;
            5'd16: b = 8'd12;   5'd17: b = 8'd53;   5'd18: b = 8'd156;  5'd19: b = 8'd93;
            5'd20: b = 8'd97;   5'd21: b = 8'd47;   5'd22: b = 8'd9;    5'd23: b = 8'd184;
            5'd24: b = 8'd68;   5'd25: b = 8'd235;  5'd26: b = 8'd67;   5'd27: b = 8'd68;
            5'd28: b = 8'd216;  5'd29: b = 8'd26;   5'd30: b = 8'd16;   default: b = 8'd93;
        endcase
        return b;
    endfunction

    state_t             state_q, state_d;
    logic [4:0]         ptr_q, ptr_d;
    logic [7:0]         match_q, match_d;
    logic [7:0]         miss_q, miss_d;
    logic               err_q, err_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic [31:0]        byte_cnt_q, byte_cnt_d;

    logic               hit;
    logic [8:0]         match_inc;
    logic [8:0]         miss_inc;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        match_d    = match_q;
        miss_d     = miss_q;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt_q;
        byte_cnt_d = byte_cnt_q;
        hit        = (I_DAT == exp_byte(ptr_q));
        match_inc  = {1'b0, match_q} + 9'd1;
        miss_inc   = {1'b0, miss_q} + 9'd1;

        if (I_STB) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (I_DAT == SYNC_BYTE) begin
                        state_d = ST_VERIFY;
                        ptr_d   = 5'd1;
                        match_d = 8'd0;
                    end
                end
                ST_VERIFY: begin
                    if (hit) begin
                        match_d = match_inc[7:0];
                        ptr_d   = ptr_q + 5'd1;
                        if (match_inc == LOCK_LIM) begin
                            state_d = ST_LOCKED;
                            miss_d  = 8'd0;
                        end
                    end else begin
                        // the offending byte is dropped, not re-tried as a sync candidate
                        state_d = ST_HUNT;
                        ptr_d   = 5'd0;
                    end
                end
                ST_LOCKED: begin
                    ptr_d = ptr_q + 5'd1;
                    if (byte_cnt_q != '1) begin
                        byte_cnt_d = byte_cnt_q + 32'd1;
                    end
                    if (hit) begin
                        miss_d = 8'd0;
                    end else begin
                        err_d  = 1'b1;
                        miss_d = miss_inc[7:0];
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                        if (miss_inc == UNLOCK_LIM) begin
                            state_d = ST_HUNT;
                            ptr_d   = 5'd0;
                            miss_d  = 8'd0;
                            match_d = 8'd0;
                        end
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    ptr_d   = 5'd0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= ST_HUNT;
            ptr_q      <= 5'd0;
            match_q    <= 8'd0;
            miss_q     <= 8'd0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            byte_cnt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            match_q    <= match_d;
            miss_q     <= miss_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign O_LOCKED   = (state_q == ST_LOCKED);
    assign O_ERROR    = err_q;
    assign O_ERR_CNT  = err_cnt_q;
    assign O_BYTE_CNT = byte_cnt_q;

endmodule

// File: doc/rom_checker.md
ROM_CHECKER -- requirements
Module: rom_checker

Interface
REQ-001 Parameter LOCK_CNT, default 32, number of consecutive matching bytes in VERIFY required to enter LOCKED (range 1..255).
REQ-002 Parameter UNLOCK_CNT, default 4, number of consecutive mismatches in LOCKED that force return to HUNT (range 1..255).
REQ-003 Parameter ERR_W, default 16, width of the error counter.
REQ-004 CLK  input  1  sole clock; all logic on rising edge.
REQ-005 RST  input  1  reset, synchronous, active-low (0 = reset).
REQ-006 I_STB  input  1  byte-valid strobe; I_DAT sampled only when 1.
REQ-007 I_DAT  input  8  received byte under test.
REQ-008 O_LOCKED  output  1  1 while the state is LOCKED.
REQ-009 O_ERROR  output  1  one-cycle pulse per mismatched byte while LOCKED.
REQ-010 O_ERR_CNT  output  ERR_W  saturating count of mismatched bytes seen while LOCKED.
REQ-011 O_BYTE_CNT  output  32  saturating count of bytes compared while LOCKED.

Function
REQ-012 Expected sequence: fixed 32-entry table, index 0..31 = 157,254,208,125,39,192,242,117,186,94,201,156,224,120,255,219,12,53,156,93,97,47,9,184,68,235,67,68,216,26,16,93; repeats cyclically.
REQ-013 5-bit expected-index pointer; increments by 1 on each accepted strobe after sync, wraps 31 -> 0.
REQ-014 States: HUNT, VERIFY, LOCKED; strobe-free cycles change no state, pointer or counter.
REQ-015 HUNT: strobe with I_DAT == 157 (table[0], unique value) -> VERIFY, pointer = 1, match counter = 0; any other byte stays in HUNT.
REQ-016 VERIFY: strobe with I_DAT == table[pointer] -> match counter +1, pointer +1; on reaching LOCK_CNT -> LOCKED in the same update.
REQ-017 VERIFY: strobe with mismatch -> HUNT, no error pulse, no counter change; the mismatching byte is not re-examined as a sync candidate.
REQ-018 LOCKED: every strobe -> O_BYTE_CNT +1, pointer +1, compare I_DAT with table[pointer].
REQ-019 LOCKED mismatch -> O_ERROR = 1 for the next cycle, O_ERR_CNT +1, consecutive-mismatch counter +1; match -> consecutive-mismatch counter = 0.
REQ-020 LOCKED: consecutive-mismatch counter reaching UNLOCK_CNT -> HUNT; O_LOCKED falls one cycle after that strobe; O_ERR_CNT and O_BYTE_CNT retain their values.
REQ-021 Latency: O_LOCKED, O_ERROR and both counters are registered and reflect a strobe in the cycle after it was sampled.
REQ-022 O_ERR_CNT holds at 2^ERR_W-1 and O_BYTE_CNT at 2^32-1; further events leave them unchanged (O_ERROR still pulses).
REQ-023 Back-to-back strobes every cycle are supported at full rate with no bubbles.
REQ-024 O_ERROR is 0 in every cycle not immediately following a LOCKED mismatch.

Reset
REQ-025 RST = 0 sampled at a rising edge: state = HUNT, pointer = 0, all internal counters = 0, O_LOCKED = 0, O_ERROR = 0, O_ERR_CNT = 0, O_BYTE_CNT = 0.
REQ-026 Reset overrides any simultaneous strobe; a strobe in the reset cycle is discarded.
REQ-027 Reset mid-LOCKED or mid-VERIFY discards lock; re-lock requires a fresh 157 plus LOCK_CNT matches.

Verification
REQ-028 Reset, then feed sequence starting at index 0 continuously -> O_LOCKED = 1 one cycle after byte 33 (157 + 32 matches), O_ERR_CNT = 0.
REQ-029 Feed 5 junk bytes (0x00) then sequence from index 0 -> stays HUNT through junk, locks after 157 + 32 matches; no O_ERROR pulse.
REQ-030 Locked, corrupt one byte (expected 224, send 225) -> single O_ERROR pulse, O_ERR_CNT = 1, O_LOCKED stays 1.
REQ-031 Locked, send 4 consecutive wrong bytes -> 4 O_ERROR pulses, O_ERR_CNT = 4, O_LOCKED = 0 after the 4th.
REQ-032 VERIFY with mismatch at 10th byte -> back to HUNT, O_ERR_CNT unchanged at 0; I_STB gaps of random length during lock -> identical result to gapless stream.
REQ-033 Assert RST = 0 for one cycle while locked with O_ERR_CNT = 3 -> next cycle all outputs 0, state HUNT.
